keccak_pad_absorb: RTL and testbench
====================================

Name: keccak_pad_absorb

Overview:
- Upstream feeder for the Keccak permutation block. Accepts a message as 64-bit little-endian words and applies SHA-3 multi-rate padding (domain byte, then pad10*1).
- Emits whole 25-lane frames in lane order x-major-in-row (lane index i = x + 5*y), one lane per handshake. Each frame is RATE_LANES message/pad lanes followed by zero capacity lanes.
- Output handshake matches the permutation block's pushin/stopin/firstin/din input.

Parameters:
RATE_LANES, 17, number of rate lanes per frame (1..24); 17 = SHA3-256
DOMAIN, 8'h06, domain-separation byte inserted after last message byte

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
pushin  input  1  input word valid
stopin  output  1  backpressure to source; word not accepted while high
lastin  input  1  word is final word of message
nbytes  input  4  valid bytes in word (0..8); only honoured with lastin, else treated as 8
din  input  64  message word, byte k in din[8k+7:8k]
pushout  output  1  lane valid
stopout  input  1  downstream backpressure
firstout  output  1  lane is lane 0 of a frame
lastout  output  1  lane is lane 24 of final frame of message
dout  output  64  lane data

Behaviour:
- Reset values: all outputs 0 (stopin 0, pushout 0, firstout 0, lastout 0, dout 0). Internal state: lane counter lc=0, state ABSORB, pending flags clear.
- Reset mid-message discards the partial frame. The next accepted word is lane 0 of a new message.
- Output register semantics:
  - Accept occurs when pushout && !stopout.
  - While pushout && stopout, dout/firstout/lastout hold stable.
  - The output register loads only when empty or being accepted that cycle.
- Latency: accepted word to dout is 1 cycle.
- Input acceptance: a word is accepted when pushin && !stopin. stopin = output register full && stopout, OR state != ABSORB.
- lc counts lanes 0..24 and wraps to 0 after lane 24. firstout = (lc==0) on the emitted lane.
- State ABSORB (lc < RATE_LANES):
  - Accepted non-last word: dout = din; lc++.
  - If lc reaches RATE_LANES, go to CAP.
- Last word with nbytes < 8, in ABSORB:
  - dout = (din masked to nbytes bytes) | DOMAIN<<(8*nbytes).
  - If lc == RATE_LANES-1, also OR 8'h80<<56 into dout and go to CAP with final flag set. Otherwise go to PAD with final flag set.
- Last word with nbytes == 8: dout = din; pending-domain flag set.
  - If lc+1 < RATE_LANES: go to PAD, whose first lane is DOMAIN (byte 0).
  - Else: go to CAP (non-final). The next frame is then generated entirely internally: lane 0 = DOMAIN, remaining rate lanes zero with 0x80 in byte 7 of lane RATE_LANES-1, then final capacity.
- State PAD: emits rate lanes internally, one per accepted output slot.
  - Lane value = zero, or DOMAIN if pending-domain, ORed with 8'h80<<56 when lc == RATE_LANES-1.
  - Domain and 0x80 in the same byte yields 8'h86 (with DOMAIN=06).
  - After lane RATE_LANES-1, go to CAP.
- State CAP: emits zero lanes for lc = RATE_LANES..24.
  - After lane 24: if final, lastout=1 on that lane and return to ABSORB with lc=0; else return to ABSORB (or to PAD when pending-domain is set) with lc=0.
- Empty message: lastin with nbytes=0 as the first word gives lane 0 = DOMAIN, lane RATE_LANES-1 = 0x80<<56, one frame total.
- nbytes > 8 with lastin is treated as 8.
- pushin while stopin is high is ignored; the source holds the word.

Test Plan:
- Reset, single word lastin nbytes=3 din=64'h0000_0000_00CC_BBAA, stopout=0 -> 25 lanes. Lane0 = 64'h0000_0000_06CC_BBAA with firstout=1; lane16 = 64'h8000_0000_0000_0000; lanes 1-15 and 17-24 are 0; lastout on lane24 only.
- 17 full words, last with lastin nbytes=8 -> frame1 lanes 0-16 equal input, lanes 17-24 zero, no lastout. Frame2: lane0 = 64'h06, lane16 = 64'h8000_0000_0000_0000, lastout on lane24. Total 50 lanes.
- 16 full words then lastin nbytes=7 din=64'h00112233_44556677 -> lane16 = 64'h8611_2233_4455_6677, one frame, lastout on lane24.
- Empty message (lastin nbytes=0, din=0xFFFF...) -> lane0 = 64'h06, lane16 = 64'h8000...0, din bytes fully masked.
- stopout held high for 5 cycles at lane 3 -> dout/firstout stable, stopin=1, no word lost or duplicated. Sequence identical to the no-stall run.
- Assert rst mid-frame at lane 9, then send a one-word message -> all outputs 0 during reset; new frame starts at lane0 with firstout=1, with no residue from the aborted frame.

Source files
------------

// File: rtl/keccak_pad_absorb.sv
// SHA-3 padding front end: absorbs 64-bit message words, applies domain byte plus
// pad10*1, and streams 25-lane frames (rate lanes, then zero capacity) to the permutation.
module keccak_pad_absorb #(
  parameter int          RATE_LANES = 17,
  parameter logic [7:0]  DOMAIN     = 8'h06
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  output logic        stopin,
  input  logic        lastin,
  input  logic [3:0]  nbytes,
  input  logic [63:0] din,
  output logic        pushout,
  input  logic        stopout,
  output logic        firstout,
  output logic        lastout,
  output logic [63:0] dout
);

  typedef enum logic [1:0] {ABSORB, PAD, CAP} state_e;

  localparam logic [4:0]  RATE_LAST = 5'(RATE_LANES - 1);
  localparam logic [4:0]  LANE_LAST = 5'd24;
  localparam logic [63:0] PAD_END   = 64'h8000_0000_0000_0000;

  state_e      state_q, state_d;
  logic [4:0]  lc_q, lc_d;
  logic        final_q, final_d;
  logic        pend_q, pend_d;
  logic        pushout_q, pushout_d;
  logic        firstout_q, firstout_d;
  logic        lastout_q, lastout_d;
  logic [63:0] dout_q, dout_d;

  logic        load_ok, in_acc, emit, short_last;
  logic [3:0]  nb_eff;
  logic [5:0]  byte_sh;
  logic [4:0]  lc_inc;
  logic [63:0] lane;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ABSORB;
      lc_q       <= '0;
      final_q    <= 1'b0;
      pend_q     <= 1'b0;
      pushout_q  <= 1'b0;
      firstout_q <= 1'b0;
      lastout_q  <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      lc_q       <= lc_d;
      final_q    <= final_d;
      pend_q     <= pend_d;
      pushout_q  <= pushout_d;
      firstout_q <= firstout_d;
      lastout_q  <= lastout_d;
      dout_q     <= dout_d;
    end
  end

  // Output / datapath decode: handshake and the lane value offered this cycle
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    load_ok    = !pushout_q || !stopout;
    stopin     = (pushout_q && stopout) || (state_q != ABSORB);
    in_acc     = pushin && !stopin;
    emit       = in_acc || ((state_q != ABSORB) && load_ok);
    nb_eff     = (!lastin || (nbytes > 4'd8)) ? 4'd8 : nbytes;
    short_last = lastin && (nb_eff < 4'd8);
    byte_sh    = {nb_eff[2:0], 3'b000};
    lc_inc     = (lc_q == LANE_LAST) ? 5'd0 : lc_q + 5'd1;
    lane       = '0;
    unique case (state_q)
      ABSORB: begin
        lane = din;
        if (short_last) begin
          lane = (din & ((64'd1 << byte_sh) - 64'd1)) | ({56'd0, DOMAIN} << byte_sh);
          if (lc_q == RATE_LAST) lane = lane | PAD_END;
        end
      end
      PAD: begin
        lane = pend_q ? {56'd0, DOMAIN} : 64'd0;
        if (lc_q == RATE_LAST) lane = lane | PAD_END;
      end
      default: lane = '0;
    endcase
  end

  // Next-state logic, including the output register load
  always_comb begin
    state_d    = state_q;
    lc_d       = lc_q;
    final_d    = final_q;
    pend_d     = pend_q;
    pushout_d  = pushout_q;
    firstout_d = firstout_q;
    lastout_d  = lastout_q;
    dout_d     = dout_q;

    if (emit) lc_d = lc_inc;

    unique case (state_q)
      ABSORB: if (in_acc) begin
        if (lastin) begin
          if (short_last) begin
            final_d = 1'b1;
            state_d = (lc_q == RATE_LAST) ? CAP : PAD;
          end else begin
            // Full last word: domain byte goes in the next rate lane, possibly next frame
            pend_d = 1'b1;
            if (lc_q == RATE_LAST) state_d = CAP;
            else begin
              state_d = PAD;
              final_d = 1'b1;
            end
          end
        end else if (lc_q == RATE_LAST) begin
          state_d = CAP;
        end
      end
      PAD: if (load_ok) begin
        pend_d = 1'b0;
        if (lc_q == RATE_LAST) state_d = CAP;
      end
      CAP: if (load_ok && (lc_q == LANE_LAST)) begin
        if (final_q) begin
          final_d = 1'b0;
          pend_d  = 1'b0;
          state_d = ABSORB;
        end else if (pend_q) begin
          final_d = 1'b1;
          state_d = PAD;
        end else begin
          state_d = ABSORB;
        end
      end
      default: state_d = ABSORB;
    endcase

    if (load_ok) begin
      pushout_d  = emit;
      firstout_d = emit && (lc_q == 5'd0);
      lastout_d  = emit && (state_q == CAP) && (lc_q == LANE_LAST) && final_q;
      if (emit) dout_d = lane;
    end
  end

  assign pushout  = pushout_q;
  assign firstout = firstout_q;
  assign lastout  = lastout_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_keccak_pad_absorb.sv
// Scoreboard bench for keccak_pad_absorb: a byte-level SHA-3 padding model predicts
// every output lane; a negedge monitor pops and compares each accepted lane.
`timescale 1ns/1ps
module tb_keccak_pad_absorb;

  localparam int         R   = 17;
  localparam logic [7:0] DOM = 8'h06;

  logic        clk = 1'b0;
  logic        rst;
  logic        pushin;
  logic        stopin;
  logic        lastin;
  logic [3:0]  nbytes;
  logic [63:0] din;
  logic        pushout;
  logic        stopout;
  logic        firstout;
  logic        lastout;
  logic [63:0] dout;

  keccak_pad_absorb #(.RATE_LANES(R), .DOMAIN(DOM)) dut (
    .clk(clk), .rst(rst), .pushin(pushin), .stopin(stopin), .lastin(lastin),
    .nbytes(nbytes), .din(din), .pushout(pushout), .stopout(stopout),
    .firstout(firstout), .lastout(lastout), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        first;
    logic        last;
  } lane_t;

  lane_t       exp_q[$];
  logic [63:0] msg_words[$];
  int          checks = 0;
  int          errors = 0;
  int          accepted_cnt = 0;
  bit          force_stall = 1'b0;
  bit          rand_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (lane #%0d)", name, act, exp, accepted_cnt);
    end
  endtask

  // Reference: SHA-3 byte-stream padding, then slice into rate lanes plus zero capacity
  task automatic push_expected(input int nb_raw);
    logic [7:0]  b[$];
    logic [63:0] w, data;
    int          nb_eff, nframes, rb;
    lane_t       e;
    rb     = 8 * R;
    nb_eff = (nb_raw > 8) ? 8 : nb_raw;
    for (int i = 0; i < msg_words.size(); i++) begin
      w = msg_words[i];
      for (int k = 0; k < ((i == msg_words.size() - 1) ? nb_eff : 8); k++)
        b.push_back(w[8*k +: 8]);
    end
    b.push_back(DOM);
    while ((b.size() % rb) != 0) b.push_back(8'h00);
    b[b.size() - 1] = b[b.size() - 1] | 8'h80;
    nframes = b.size() / rb;
    for (int f = 0; f < nframes; f++)
      for (int l = 0; l < 25; l++) begin
        data = '0;
        if (l < R)
          for (int k = 0; k < 8; k++) data[8*k +: 8] = b[f*rb + l*8 + k];
        e.data  = data;
        e.first = (l == 0);
        e.last  = (f == nframes - 1) && (l == 24);
        exp_q.push_back(e);
      end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted
  task automatic send_word(input logic [63:0] w, input logic last, input logic [3:0] nb);
    bit timed_out;
    timed_out = 1'b1;
    pushin = 1'b1;
    din    = w;
    lastin = last;
    nbytes = nb;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      if (!stopin) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("accept_timeout", 64'(timed_out), 64'd0);
    @(posedge clk);
    #1;
    pushin = 1'b0;
    lastin = 1'b0;
  endtask

  task automatic send_msg(input int nb_raw);
    push_expected(nb_raw);
    for (int i = 0; i < msg_words.size(); i++) begin
      if (i == msg_words.size() - 1) send_word(msg_words[i], 1'b1, 4'(nb_raw));
      else send_word(msg_words[i], 1'b0, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic wait_drain();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pushout"}, 64'(pushout), 64'd0);
    check({tag, "_stopin"}, 64'(stopin), 64'd0);
    check({tag, "_firstout"}, 64'(firstout), 64'd0);
    check({tag, "_lastout"}, 64'(lastout), 64'd0);
    check({tag, "_dout"}, dout, 64'd0);
  endtask

  always @(posedge clk) begin
    #2;
    stopout = force_stall || (rand_stall && ($urandom_range(0, 3) == 0));
  end

  // Monitor: stability under stall, backpressure propagation, scoreboard compare
  bit          prev_stall = 1'b0;
  logic [63:0] prev_dout;
  logic        prev_first, prev_last;
  always @(negedge clk) begin
    lane_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_dout_stable", dout, prev_dout);
        check("stall_first_stable", 64'(firstout), 64'(prev_first));
        check("stall_last_stable", 64'(lastout), 64'(prev_last));
      end
      if (pushout && stopout) check("stopin_under_stall", 64'(stopin), 64'd1);
      if (pushout && !stopout) begin
        if (exp_q.size() == 0) begin
          check("unexpected_lane", dout, 64'hxxxx_xxxx_xxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("lane_data", dout, e.data);
          check("lane_first", 64'(firstout), 64'(e.first));
          check("lane_last", 64'(lastout), 64'(e.last));
          accepted_cnt++;
        end
      end
      prev_stall = pushout && stopout;
      prev_dout  = dout;
      prev_first = firstout;
      prev_last  = lastout;
    end
  end

  initial begin
    lane_t e;
    int    base;
    rst = 1'b1; pushin = 1'b0; lastin = 1'b0; nbytes = '0; din = '0; stopout = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // One short word
    msg_words = {64'h0000_0000_00CC_BBAA};
    send_msg(3);
    wait_drain();

    // Exactly one rate block of full words: padding spills into a second frame
    msg_words.delete();
    for (int i = 0; i < R; i++) msg_words.push_back({$urandom, $urandom});
    send_msg(8);
    wait_drain();

    // Domain and 0x80 share the top byte of the last rate lane
    msg_words.delete();
    for (int i = 0; i < R - 1; i++) msg_words.push_back({$urandom, $urandom});
    msg_words.push_back(64'h0011_2233_4455_6677);
    send_msg(7);
    wait_drain();

    // Empty message: input bytes fully masked
    msg_words = {64'hFFFF_FFFF_FFFF_FFFF};
    send_msg(0);
    wait_drain();

    // Oversized nbytes on the last word acts as 8
    msg_words = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    send_msg(13);
    wait_drain();

    // Five-cycle downstream stall while lane 3 is presented
    msg_words.delete();
    for (int i = 0; i < 6; i++) msg_words.push_back({$urandom, $urandom});
    base = accepted_cnt;
    fork
      send_msg(5);
      begin
        for (int cyc = 0; cyc < 1000; cyc++) begin
          @(posedge clk); #1;
          if (accepted_cnt == base + 3) break;
        end
        force_stall = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        force_stall = 1'b0;
      end
    join
    wait_drain();

    // Reset partway through a frame, then a fresh one-word message
    for (int i = 0; i < 10; i++) begin
      e.data = {$urandom, $urandom}; e.first = (i == 0); e.last = 1'b0;
      exp_q.push_back(e);
      send_word(e.data, 1'b0, 4'd8);
    end
    wait_drain();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    msg_words = {64'h1122_3344_5566_7788};
    send_msg(4);
    wait_drain();

    // Randomized messages with random downstream backpressure
    rand_stall = 1'b1;
    for (int m = 0; m < 12; m++) begin
      msg_words.delete();
      for (int i = 0; i < $urandom_range(1, 40); i++) msg_words.push_back({$urandom, $urandom});
      send_msg($urandom_range(0, 15));
    end
    wait_drain();
    rand_stall = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
